// File: rtl/master_port.sv
// -----------------------------------------------------------------------------
// master_port
//
// Bridges a simple parallel device-side request interface to a bit-serial
// master port on a shared bus. One transaction at a time:
//
//   IDLE  -> accept a request (address, write data, mode) from the device
//   REQ   -> ask the arbiter for the bus and wait for the grant
//   ADDR  -> shift the address out LSB first, one bit per cycle
//   WDATA -> (write) shift the write data out LSB first
//   RWAIT -> (read) wait for the slave's first valid data bit
//   RDATA -> (read) collect the remaining data bits LSB first
//   DONE  -> one-cycle completion pulse, then back to IDLE
//
// A read that sees TIMEOUT consecutive cycles without svalid is abandoned:
// DONE is entered with dtimeout set and drdata keeps its previous value.
//
// Every output is decoded from registered state only; no input reaches an
// output combinationally.
//
// Ports
//   clk       clock, rising edge
//   rstn      synchronous active-low reset
//   dreq      device request, honoured only while dready=1
//   dmode     device mode: 1 = write, 0 = read
//   daddr     device target address
//   dwdata    device write data
//   dready    block is idle and will accept dreq this cycle
//   drdata    data word of the last successful read
//   ddone     one-cycle transaction-complete pulse
//   dtimeout  one-cycle pulse with ddone when a read timed out
//   mbreq     bus request to the arbiter
//   mbgrant   bus grant from the arbiter (only looked at in REQ)
//   mwdata    serial address / write-data bit to the slave
//   mmode     mode to the slave: 1 = write, 0 = read
//   mvalid    mwdata carries a valid bit
//   srdata    serial read-data bit from the slave
//   svalid    srdata carries a valid bit
// -----------------------------------------------------------------------------
module master_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dreq,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dready,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  ddone,
  output logic                  dtimeout,
  output logic                  mbreq,
  input  logic                  mbgrant,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  srdata,
  input  logic                  svalid
);

  // The bit counter walks both the address and the data phases, so it is
  // sized for whichever field is wider.
  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // TIMEOUT is at most 255, so eight bits always hold the idle run length.
  // The timeout fires on the edge that completes the TIMEOUT-th idle cycle,
  // i.e. when the count of earlier idle cycles equals TIMEOUT-1.
  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] IDLE_ONE  = 8'd1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    WDATA,
    RWAIT,
    RDATA,
    DONE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;        // bit position within ADDR/WDATA/RDATA
  logic [7:0]            idle_cnt;   // consecutive svalid=0 cycles while reading
  logic                  mode_q;     // latched transaction mode
  logic                  timeout_q;  // current DONE was reached by timeout
  logic [ADDR_WIDTH-1:0] addr_sh;    // address, shifted right as bits go out
  logic [DATA_WIDTH-1:0] wdata_sh;   // write data, shifted right as bits go out
  logic [DATA_WIDTH-1:0] rdata_sh;   // read bits enter at the MSB and move down

  // Read data arrives LSB first. Shifting each new bit in at the MSB leaves
  // the first-received bit at position 0 once all DATA_WIDTH bits are in,
  // so the completed word is simply the shift register plus the final bit.
  logic [DATA_WIDTH-1:0] rdata_next;
  assign rdata_next = {srdata, rdata_sh[DATA_WIDTH-1:1]};

  // ---------------------------------------------------------------------------
  // State, counters and data registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block updates from the values present before the edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      idle_cnt  <= '0;
      mode_q    <= 1'b0;
      timeout_q <= 1'b0;
      addr_sh   <= '0;
      wdata_sh  <= '0;
      rdata_sh  <= '0;
      drdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq) begin
            mode_q    <= dmode;
            addr_sh   <= daddr;
            wdata_sh  <= dwdata;
            timeout_q <= 1'b0;
            state     <= REQ;
          end
        end

        REQ: begin
          // Wait for the arbiter as long as it takes; there is no give-up.
          if (mbgrant) begin
            cnt   <= '0;
            state <= ADDR;
          end
        end

        ADDR: begin
          addr_sh <= addr_sh >> 1;
          if (cnt == ADDR_LAST) begin
            cnt      <= '0;
            idle_cnt <= '0;
            rdata_sh <= '0;
            state    <= mode_q ? WDATA : RWAIT;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        WDATA: begin
          wdata_sh <= wdata_sh >> 1;
          if (cnt == DATA_LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        RWAIT, RDATA: begin
          if (svalid) begin
            rdata_sh <= rdata_next;
            idle_cnt <= '0;
            if (cnt == DATA_LAST) begin
              // Last bit: publish the whole word on the same edge.
              drdata <= rdata_next;
              cnt    <= '0;
              state  <= DONE;
            end else begin
              // Gaps in RDATA simply leave cnt where it is.
              cnt   <= cnt + CNT_ONE;
              state <= RDATA;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            // Slave went quiet for too long: finish without touching drdata.
            timeout_q <= 1'b1;
            idle_cnt  <= '0;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            idle_cnt <= idle_cnt + IDLE_ONE;
          end
        end

        DONE: begin
          timeout_q <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case, so no state leaves an
  // output unassigned and no latch is inferred.
  always_comb begin
    dready = 1'b0;
    mbreq  = 1'b0;
    mvalid = 1'b0;
    mmode  = 1'b0;
    mwdata = 1'b0;
    ddone  = 1'b0;
    case (state)
      IDLE: begin
        dready = 1'b1;
      end
      REQ, RWAIT, RDATA: begin
        mbreq = 1'b1;
      end
      ADDR: begin
        mbreq  = 1'b1;
        mvalid = 1'b1;
        mmode  = mode_q;
        mwdata = addr_sh[0];
      end
      WDATA: begin
        mbreq  = 1'b1;
        mvalid = 1'b1;
        mmode  = 1'b1;
        mwdata = wdata_sh[0];
      end
      DONE: begin
        ddone = 1'b1;
      end
      default: begin
        dready = 1'b0;
      end
    endcase
  end

  // timeout_q is only ever set on the way into DONE; gating with the state
  // keeps the pulse strictly coincident with ddone.
  assign dtimeout = (state == DONE) && timeout_q;

endmodule

// File: tb/tb_master_port.sv
// -----------------------------------------------------------------------------
// tb_master_port
//
// Self-checking bench for master_port (ADDR_WIDTH=12, DATA_WIDTH=8,
// TIMEOUT=16). Directed transactions come from a table of stimulus records
// with hand-derived completion cycle, read data and timeout flag; reset
// mid-transaction is a hand-written sequence; random transactions take their
// expected values from a behavioural model of the slave-side read rules.
//
// For every cycle of a transaction the bench predicts the full output vector
// {dready, mbreq, mvalid, mmode, mwdata, ddone, dtimeout} from the cycle index
// alone. Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_master_port;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          dreq = 1'b0;
  logic          dmode = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [DW-1:0] dwdata = '0;
  logic          dready;
  logic [DW-1:0] drdata;
  logic          ddone;
  logic          dtimeout;
  logic          mbreq;
  logic          mbgrant = 1'b0;
  logic          mwdata;
  logic          mmode;
  logic          mvalid;
  logic          srdata = 1'b0;
  logic          svalid = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] last_rd = '0;

  always #5 clk = ~clk;

  master_port #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .dreq    (dreq),
    .dmode   (dmode),
    .daddr   (daddr),
    .dwdata  (dwdata),
    .dready  (dready),
    .drdata  (drdata),
    .ddone   (ddone),
    .dtimeout(dtimeout),
    .mbreq   (mbreq),
    .mbgrant (mbgrant),
    .mwdata  (mwdata),
    .mmode   (mmode),
    .mvalid  (mvalid),
    .srdata  (srdata),
    .svalid  (svalid)
  );

  typedef struct {
    string         name;
    bit            mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            g;      // REQ cycles with mbgrant low before the grant
    logic [31:0]   pv;     // slave svalid per read-phase cycle (bit i = cycle i)
    logic [31:0]   pd;     // slave srdata per read-phase cycle
    bit            noise;  // toggle ignored inputs while busy
    int            done;   // cycle of ddone, counted from the dreq cycle
    logic [DW-1:0] rd;     // drdata expected at ddone
    bit            to;     // dtimeout expected at ddone
  } vec_t;

  function automatic logic [6:0] sig();
    return {dready, mbreq, mvalid, mmode, mwdata, ddone, dtimeout};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Slave-side read rules: bits land LSB first on svalid cycles, a run of TO
  // consecutive empty cycles abandons the read. Returns the index of the last
  // read-phase cycle, whether it timed out, and the assembled word.
  function automatic void read_model(input logic [31:0] pv, input logic [31:0] pd,
                                     output int e, output bit to, output logic [DW-1:0] word);
    int got  = 0;
    int idle = 0;
    word = '0;
    to   = 1'b0;
    e    = -1;
    for (int i = 0; i < 300; i++) begin
      bit v;
      v = (i < 32) ? pv[i] : 1'b0;
      if (v) begin
        word[got] = pd[i];
        got++;
        idle = 0;
        if (got == DW) begin
          e = i;
          return;
        end
      end else begin
        idle++;
        if (idle == TO) begin
          e  = i;
          to = 1'b1;
          return;
        end
      end
    end
  endfunction

  // Runs one transaction starting in an IDLE cycle and checks every cycle up to
  // and including the IDLE cycle that follows DONE.
  task automatic run_txn(input string name, input bit mode, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int g, input logic [31:0] pv,
                         input logic [31:0] pd, input bit noise, input int done,
                         input logic [DW-1:0] exp_rd, input bit exp_to);
    int rd0;
    rd0 = g + 2 + AW;  // first cycle after the address phase
    for (int c = 0; c <= done + 1; c++) begin
      logic [6:0] e_sig;
      int i;
      @(negedge clk);
      if (c == 0 || c == done + 1)       e_sig = 7'b1000000;
      else if (c <= g + 1)               e_sig = 7'b0100000;
      else if (c < rd0)                  e_sig = {3'b011, mode, addr[c-g-2], 2'b00};
      else if (mode && c < rd0 + DW)     e_sig = {4'b0111, wd[c-rd0], 2'b00};
      else if (c < done)                 e_sig = 7'b0100000;
      else                               e_sig = {5'b00000, 1'b1, exp_to};
      check($sformatf("%s c%0d outputs", name, c), 32'(sig()), 32'(e_sig));
      if (c == done)
        check($sformatf("%s drdata", name), 32'(drdata), 32'(exp_rd));

      // Device side: the request itself, then noise that must be ignored.
      if (c == 0) begin
        dreq   = 1'b1;
        dmode  = mode;
        daddr  = addr;
        dwdata = wd;
      end else if (noise && c <= done) begin
        dreq   = 1'($urandom_range(1));
        dmode  = 1'($urandom_range(1));
        daddr  = AW'($urandom);
        dwdata = DW'($urandom);
      end else begin
        dreq = 1'b0;
      end

      // Arbiter side.
      if (c >= 1 && c <= g)  mbgrant = 1'b0;
      else if (c == g + 1)   mbgrant = 1'b1;
      else if (noise)        mbgrant = 1'($urandom_range(1));
      else                   mbgrant = 1'b1;

      // Slave side.
      i = c - rd0;
      if (!mode && i >= 0 && c < done) begin
        svalid = (i < 32) ? pv[i] : 1'b0;
        srdata = (i < 32) ? pd[i] : 1'b0;
      end else if (noise) begin
        svalid = 1'($urandom_range(1));
        srdata = 1'($urandom_range(1));
      end else begin
        svalid = 1'b0;
        srdata = 1'b0;
      end
    end
  endtask

  initial begin
    vec_t vecs[8];
    logic [AW-1:0] ra;

    vecs[0] = '{"wr_a5c",      1'b1, 12'hA5C, 8'h3E, 0,  32'h0,        32'h0,        1'b0, 22, 8'h00, 1'b0};
    vecs[1] = '{"rd_001_gap",  1'b0, 12'h001, 8'h00, 0,  32'h00003DE0, 32'h00003060, 1'b0, 28, 8'hC3, 1'b0};
    vecs[2] = '{"rd_timeout",  1'b0, 12'h7FF, 8'h00, 0,  32'h0,        32'h0,        1'b0, 30, 8'hC3, 1'b1};
    vecs[3] = '{"wr_grant10",  1'b1, 12'h123, 8'h81, 10, 32'h0,        32'h0,        1'b0, 32, 8'hC3, 1'b0};
    vecs[4] = '{"rd_burst",    1'b0, 12'h0F0, 8'h00, 3,  32'h000000FF, 32'h0000005A, 1'b0, 25, 8'h5A, 1'b0};
    vecs[5] = '{"rd_part_to",  1'b0, 12'h800, 8'h00, 0,  32'h00000007, 32'h00000005, 1'b0, 33, 8'h5A, 1'b1};
    vecs[6] = '{"rd_idle15",   1'b0, 12'h555, 8'h00, 0,  32'h007F8000, 32'h007F8000, 1'b0, 37, 8'hFF, 1'b0};
    vecs[7] = '{"wr_noise",    1'b1, 12'hAAA, 8'hC5, 2,  32'h0,        32'h0,        1'b1, 24, 8'hFF, 1'b0};

    // Reset state.
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 32'(sig()), 32'(7'b1000000));
    check("reset drdata", 32'(drdata), 32'h0);
    rstn = 1'b1;

    // Directed table.
    for (int k = 0; k < 8; k++) begin
      run_txn(vecs[k].name, vecs[k].mode, vecs[k].addr, vecs[k].wdata, vecs[k].g,
              vecs[k].pv, vecs[k].pd, vecs[k].noise, vecs[k].done, vecs[k].rd, vecs[k].to);
    end

    // Reset while address bit 5 is on the bus.
    ra = 12'h5A3;
    @(negedge clk);
    dreq = 1'b1; dmode = 1'b1; daddr = ra; dwdata = 8'h96; mbgrant = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      dreq = 1'b0;
    end
    check("rst_mid addr bit5", 32'(sig()), 32'({3'b011, 1'b1, ra[5], 2'b00}));
    rstn = 1'b0;
    @(negedge clk);
    check("rst_mid outputs", 32'(sig()), 32'(7'b1000000));
    check("rst_mid drdata", 32'(drdata), 32'h0);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_mid idle%0d", c), 32'(sig()), 32'(7'b1000000));
    end
    last_rd = '0;
    run_txn("wr_after_rst", 1'b1, 12'h3C7, 8'h69, 0, 32'h0, 32'h0, 1'b0, 22, 8'h00, 1'b0);

    // Random transactions against the model.
    for (int t = 0; t < 30; t++) begin
      bit            m;
      logic [AW-1:0] a;
      logic [DW-1:0] w;
      int            g;
      logic [31:0]   pv;
      logic [31:0]   pd;
      int            e;
      bit            to;
      logic [DW-1:0] word;
      int            done;
      m  = 1'($urandom_range(1));
      a  = AW'($urandom);
      w  = DW'($urandom);
      g  = $urandom_range(0, 4);
      pv = $urandom | $urandom;
      if (t % 4 == 0) pv = pv & ~(32'h0001FFFF << $urandom_range(0, 10));
      pd = $urandom;
      if (m) begin
        done = g + 2 + AW + DW;
        to   = 1'b0;
      end else begin
        read_model(pv, pd, e, to, word);
        done = g + 3 + AW + e;
        if (!to) last_rd = word;
      end
      run_txn($sformatf("rand%0d", t), m, a, w, g, pv, pd, 1'b1, done, last_rd, to);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/master_port.md
MASTER_PORT -- requirements
Module: master_port

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 12, address bits; DATA_WIDTH, default 8, data bits; TIMEOUT, default 255, max consecutive idle read-wait cycles (1..255).
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 dreq  input  1  device request, sampled only when dready=1.
REQ-005 dmode  input  1  1=write, 0=read.
REQ-006 daddr  input  ADDR_WIDTH  target address.
REQ-007 dwdata  input  DATA_WIDTH  write data.
REQ-008 dready  output  1  block idle, request accepted this cycle if dreq=1.
REQ-009 drdata  output  DATA_WIDTH  last read data.
REQ-010 ddone  output  1  one-cycle transaction-complete pulse.
REQ-011 dtimeout  output  1  one-cycle pulse, coincident with ddone, when a read timed out.
REQ-012 mbreq  output  1  bus request to arbiter.
REQ-013 mbgrant  input  1  bus grant from arbiter.
REQ-014 mwdata  output  1  serial address/write-data bit to slave.
REQ-015 mmode  output  1  1=write, 0=read, to slave.
REQ-016 mvalid  output  1  mwdata valid.
REQ-017 srdata  input  1  serial read-data bit from slave.
REQ-018 svalid  input  1  srdata valid.

Function
REQ-019 FSM states SHALL be IDLE, REQ, ADDR, WDATA, RWAIT, RDATA, DONE; all outputs SHALL be Moore-decoded from registered state/counters/data, with no combinational input-to-output path.
REQ-020 IDLE: dready=1; dreq=1 SHALL latch daddr, dwdata, dmode into internal registers and move to REQ next cycle; dreq=0 stays IDLE.
REQ-021 REQ: mbreq=1; mbgrant=1 SHALL move to ADDR with bit counter=0; otherwise stay REQ indefinitely.
REQ-022 mbreq SHALL be 1 in REQ, ADDR, WDATA, RWAIT, RDATA and 0 in IDLE, DONE; mbgrant SHALL be ignored outside REQ.
REQ-023 ADDR: mvalid=1, mmode=latched mode, mwdata=addr[counter], LSB first, exactly ADDR_WIDTH consecutive cycles; at counter=ADDR_WIDTH-1 counter clears and state moves to WDATA (mode 1) or RWAIT (mode 0).
REQ-024 WDATA: mvalid=1, mmode=1, mwdata=wdata[counter], LSB first, exactly DATA_WIDTH consecutive cycles, then DONE.
REQ-025 RWAIT/RDATA: mvalid=0, mmode=0, mwdata=0; each cycle with svalid=1 SHALL write srdata into rdata shift position counter (LSB first) and increment counter; RWAIT moves to RDATA on first svalid; svalid gaps in RDATA SHALL hold counter.
REQ-026 Capture of bit DATA_WIDTH-1 SHALL move to DONE and update drdata with the assembled word at that edge.
REQ-027 An idle counter SHALL count consecutive svalid=0 cycles in RWAIT/RDATA, clearing on svalid=1; reaching TIMEOUT SHALL move to DONE with dtimeout asserted, drdata unchanged.
REQ-028 DONE: ddone=1 for exactly one cycle, dready=0, then IDLE; drdata SHALL hold until the next successful read.
REQ-029 Outside ADDR/WDATA, mvalid=0, mwdata=0, mmode=0.
REQ-030 Write latency with mbgrant already high: dreq edge to ddone = 2+ADDR_WIDTH+DATA_WIDTH cycles (22 at defaults).
REQ-031 dreq while dready=0 SHALL be ignored; no queuing.

Reset
REQ-032 rstn=0 at any rising edge, including mid-transaction, SHALL force IDLE, clear all counters and internal registers, and on the next cycle give dready=1, drdata=0, ddone=0, dtimeout=0, mbreq=0, mvalid=0, mwdata=0, mmode=0.
REQ-033 A transaction interrupted by reset SHALL NOT produce ddone.

Verification
REQ-034 Write daddr=0xA5C, dwdata=0x3E, mbgrant=1 -> mvalid high 20 cycles, mmode=1, mwdata 0,0,1,1,1,0,1,0,0,1,0,1 then 0,1,1,1,1,1,0,0; ddone 22 cycles after dreq.
REQ-035 Read daddr=0x001, slave returns svalid bits 1,1,0,0,0,0,1,1 after 5-cycle wait with one mid-word svalid gap -> mmode=0 during address, drdata=0xC3, ddone once, dtimeout=0.
REQ-036 Read with svalid never asserted, TIMEOUT=16 -> ddone and dtimeout together 16 cycles after RWAIT entry, drdata retains prior value.
REQ-037 mbgrant held low 10 cycles after dreq -> mbreq high, mvalid low throughout; ADDR begins the cycle after mbgrant rises.
REQ-038 rstn low during address bit 5 -> next cycle dready=1, mbreq=0, mvalid=0, no ddone; new write then completes correctly.
REQ-039 dreq pulsed during WDATA with different daddr -> ignored; bus traffic and ddone match the first request only.
